pc_unit: RTL and testbench

Program-counter stage of the single-cycle MIPS datapath: a WIDTH-bit clocked PC register with next-address selection (sequential, branch, jump, jump-register), stall hold, and a sticky fault state for misaligned register jumps. It consumes the control and target fields from decode/ALU and feeds the current address to instruction memory and PC+4 to the link/branch logic.

---
 rtl/mips_pkg.sv | 13 +
 rtl/pc_reg.sv | 22 ++
 rtl/pc_unit.sv | 85 ++++++++
 tb/tb_pc_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS program-counter stage.
package mips_pkg;

    localparam int unsigned WIDTH = 32;
    localparam logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000;
    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } pc_state_t;

endpackage

// File: rtl/pc_reg.sv
// WIDTH-bit register with load enable and asynchronous active-high reset.
module pc_reg #(
    parameter int unsigned WIDTH = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Load d when enabled; reset forces the reset value immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RESET_VALUE;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: next-address selection, stall hold and a sticky
// fault state entered on a misaligned register jump.
module pc_unit #(
    parameter int unsigned WIDTH = mips_pkg::WIDTH,
    parameter logic [WIDTH-1:0] RESET_VECTOR = mips_pkg::RESET_VECTOR
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [15:0]      branch_offset,
    input  logic             jump,
    input  logic [25:0]      jump_target,
    input  logic             jr,
    input  logic [WIDTH-1:0] jr_addr,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             fault
);

    import mips_pkg::*;

    pc_state_t        state;
    logic             advance;
    logic             jr_misaligned;
    logic             pc_en;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] branch_disp;

    assign pc_plus4      = pc + WIDTH'(INSTR_BYTES);
    assign advance       = (state == RUN) && !stall;
    assign jr_misaligned = jr && (jr_addr[1:0] != 2'b00);
    // A misaligned jr freezes the pc at the faulting address.
    assign pc_en         = advance && !jr_misaligned;
    assign branch_disp   = {{(WIDTH-18){branch_offset[15]}}, branch_offset, 2'b00};

    // Fixed-priority next-address select: jr, jump, branch, sequential.
    always_comb begin
        pc_next = pc_plus4;
        if (jr) begin
            pc_next = jr_addr;
        end else if (jump) begin
            pc_next = {pc_plus4[WIDTH-1:WIDTH-4], jump_target, 2'b00};
        end else if (branch_taken) begin
            pc_next = pc_plus4 + branch_disp;
        end
    end

    pc_reg #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VECTOR)
    ) u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .en    (pc_en),
        .d     (pc_next),
        .q     (pc)
    );

    // RUN/FAULT state machine with registered sticky fault flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            fault <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (advance && jr_misaligned) begin
                        state <= FAULT;
                        fault <= 1'b1;
                    end
                end
                FAULT: begin
                    state <= FAULT;
                    fault <= 1'b1;
                end
                default: begin
                    state <= FAULT;
                    fault <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a driver applies directed and random controls
// and queues the expected pc/fault from a reference model; a monitor compares.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        jump;
    logic [25:0] jump_target;
    logic        jr;
    logic [31:0] jr_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fault;

    typedef struct {
        logic [31:0] pc;
        logic        fault;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    logic [31:0] m_pc;
    logic        m_fault;

    always #5 clk = ~clk;

    pc_unit #(.WIDTH(32), .RESET_VECTOR(32'h0000_0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_target   (jump_target),
        .jr            (jr),
        .jr_addr       (jr_addr),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .fault         (fault)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: next pc from the architectural rules.
    task automatic model_edge(input logic st, input logic br, input logic [15:0] off,
                              input logic j, input logic [25:0] tgt,
                              input logic r, input logic [31:0] ra);
        logic [31:0] seq;
        int          disp;
        if (m_fault || st) return;
        seq = m_pc + 32'd4;
        if (r) begin
            if (ra % 4 == 0) m_pc = ra;
            else m_fault = 1'b1;
        end else if (j) begin
            m_pc = (seq & 32'hF000_0000) | ({6'd0, tgt} * 4);
        end else if (br) begin
            disp = $signed(off);
            m_pc = seq + 32'(disp * 4);
        end else begin
            m_pc = seq;
        end
    endtask

    // Apply one cycle of controls (called just after a falling edge).
    task automatic step(input logic st, input logic br, input logic [15:0] off,
                        input logic j, input logic [25:0] tgt,
                        input logic r, input logic [31:0] ra);
        exp_t e;
        stall = st; branch_taken = br; branch_offset = off;
        jump = j; jump_target = tgt; jr = r; jr_addr = ra;
        @(posedge clk);
        model_edge(st, br, off, j, tgt, r, ra);
        e.pc = m_pc;
        e.fault = m_fault;
        sb_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    endtask

    task automatic set_pc(input logic [31:0] a);
        step(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, a);
    endtask

    // Mid-cycle reset pulse, checked while asserted and after release.
    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        m_pc = 32'h0;
        m_fault = 1'b0;
        check("async_reset_pc", pc, m_pc);
        check("async_reset_fault", {31'd0, fault}, {31'd0, m_fault});
        #1;
        reset = 1'b0;
        #1;
        check("post_reset_pc", pc, m_pc);
    endtask

    // Monitor: pops one expectation per cycle and compares DUT outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("pc", pc, e.pc);
                check("pc_plus4", pc_plus4, e.pc + 32'd4);
                check("fault", {31'd0, fault}, {31'd0, e.fault});
            end
        end
    end

    initial begin
        logic [31:0] ra;
        int          wait_cycles;
        reset = 1'b1;
        stall = 1'b0; branch_taken = 1'b0; branch_offset = '0;
        jump = 1'b0; jump_target = '0; jr = 1'b0; jr_addr = '0;
        m_pc = 32'h0;
        m_fault = 1'b0;
        @(negedge clk);
        #1;
        check("reset_pc", pc, 32'h0);
        check("reset_fault", {31'd0, fault}, 32'd0);
        reset = 1'b0;

        // Sequential fetch
        idle(); idle(); idle();

        // Branches backward and forward
        set_pc(32'h0000_0100);
        step(1'b0, 1'b1, 16'hFFFE, 1'b0, 26'h0, 1'b0, 32'h0);
        set_pc(32'h0000_0100);
        step(1'b0, 1'b1, 16'h0003, 1'b0, 26'h0, 1'b0, 32'h0);

        // Jump, and jump beating a simultaneous branch
        set_pc(32'h4000_0000);
        step(1'b0, 1'b0, 16'h0, 1'b1, 26'h000_0010, 1'b0, 32'h0);
        set_pc(32'h4000_0000);
        step(1'b0, 1'b1, 16'h0040, 1'b1, 26'h000_0010, 1'b0, 32'h0);

        // Misaligned jr enters the sticky fault state
        set_pc(32'h0000_0010);
        step(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h0000_2002);
        step(1'b0, 1'b0, 16'h0, 1'b1, 26'h123_4567, 1'b0, 32'h0);
        step(1'b0, 1'b1, 16'h0004, 1'b0, 26'h0, 1'b1, 32'h0000_0800);
        pulse_reset();

        // Wrap-around and stall masking a misaligned jr
        set_pc(32'hFFFF_FFFC);
        idle();
        step(1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h0000_0003);
        step(1'b1, 1'b1, 16'h0010, 1'b1, 26'h0, 1'b0, 32'h0);

        // Reset between edges
        set_pc(32'h0000_0040);
        pulse_reset();
        idle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 7) != 0) ra[1:0] = 2'b00;
            if (m_fault && $urandom_range(0, 3) == 0) begin
                pulse_reset();
            end else begin
                step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, 16'($urandom),
                     $urandom_range(0, 5) == 0, 26'($urandom),
                     $urandom_range(0, 7) == 0, ra);
            end
        end

        wait_cycles = 0;
        while (sb_q.size() > 0 && wait_cycles < 10) begin
            @(negedge clk);
            wait_cycles++;
        end
        #1;
        if (sb_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
